// File: rtl/interrupt_pkg.sv
// ---------------------------------------------------------------------------
// interrupt_pkg
// Shared definitions for the interrupt controller and the SPR bank.
//   NCAUSE    : number of cause lines (width of mca / pend / sr_mask)
//   EXT_BASE  : first external (sticky) cause index
//   NMI_MASK  : causes that ignore the status-register mask
//   RPT_MASK  : causes whose handler repeats the faulting instruction
//   SISR      : ISR entry address
//   state_e   : controller state {RUN, JISR, ISR}
// ---------------------------------------------------------------------------
package interrupt_pkg;

  localparam int NCAUSE   = 23;
  localparam int EXT_BASE = 12;

  localparam logic [NCAUSE-1:0] NMI_MASK = 23'h000001;
  localparam logic [NCAUSE-1:0] RPT_MASK = 23'h000060;
  localparam logic [31:0]       SISR     = 32'h0000_0100;

  // External causes occupy the upper bits; everything below is internal.
  localparam logic [NCAUSE-1:0] EXT_BITS = {NCAUSE{1'b1}} << EXT_BASE;
  localparam logic [NCAUSE-1:0] INT_BITS = ~EXT_BITS;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    JISR = 2'd1,
    ISR  = 2'd2
  } state_e;

  // Raw cause lines that count this cycle: externals always, internals only
  // when an instruction actually retires.
  function automatic logic [NCAUSE-1:0] qualify_causes(
    input logic [NCAUSE-1:0] cause,
    input logic              commit
  );
    return (cause & EXT_BITS) | (commit ? (cause & INT_BITS) : '0);
  endfunction

endpackage

// File: rtl/interrupt_ctrl_cause_latch.sv
// ---------------------------------------------------------------------------
// cause_latch
// Sticky pending register for external cause lines.
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   set_i  in   WIDTH  bits to mark pending this cycle
//   clr_i  in   WIDTH  bits reported to software this cycle
//   pend_o out  WIDTH  current pending bits
// A bit that is set and cleared on the same edge stays set, so a source that
// is still asserting while it is being reported is not lost.
// ---------------------------------------------------------------------------
module cause_latch
  import interrupt_pkg::*;
#(
  parameter int WIDTH = NCAUSE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] set_i,
  input  logic [WIDTH-1:0] clr_i,
  output logic [WIDTH-1:0] pend_o
);

  logic [WIDTH-1:0] pend_q;
  logic [WIDTH-1:0] pend_d;

  assign pend_d = (pend_q & ~clr_i) | set_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/interrupt_ctrl.sv
// ---------------------------------------------------------------------------
// interrupt_ctrl
// Collects internal/external cause lines, masks them and raises jisr toward
// the SPR bank and PC logic; tracks ISR execution until rfe.
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   commit_i    in   instruction retires; qualifies internal causes
//   cause_in_i  in   NCAUSE raw cause lines
//   sr_mask_i   in   NCAUSE interrupt enable mask (1 = enabled)
//   rfe_i       in   return-from-exception retires
//   jisr_o      out  one-cycle interrupt pulse
//   mca_o       out  NCAUSE masked cause vector reported with jisr
//   rpt_o       out  repeat-type interrupt, valid with jisr
//   isr_pc_o    out  32 ISR start address while jisr is high, else 0
//   in_isr_o    out  high while an ISR is executing
//   pend_o      out  NCAUSE sticky external pending bits
// Configuration macro: INT_NEST_EN (when defined, maskable causes may nest
// inside an ISR through sr_mask; otherwise only NMI causes are taken there).
// ---------------------------------------------------------------------------
module interrupt_ctrl
  import interrupt_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              commit_i,
  input  logic [NCAUSE-1:0] cause_in_i,
  input  logic [NCAUSE-1:0] sr_mask_i,
  input  logic              rfe_i,
  output logic              jisr_o,
  output logic [NCAUSE-1:0] mca_o,
  output logic              rpt_o,
  output logic [31:0]       isr_pc_o,
  output logic              in_isr_o,
  output logic [NCAUSE-1:0] pend_o
);

  state_e            state_q;
  logic              jisr_q;
  logic [NCAUSE-1:0] mca_q;
  logic              rpt_q;
  logic [31:0]       isr_pc_q;
  logic              in_isr_q;

  logic [NCAUSE-1:0] pend;
  logic [NCAUSE-1:0] cand;
  logic [NCAUSE-1:0] enMask;
  logic [NCAUSE-1:0] elig;
  logic              take;

  assign cand = pend | qualify_causes(cause_in_i, commit_i);

  // Which causes may be taken depends on where we are. During the JISR
  // pulse nothing is taken, which also keeps pend from being cleared there.
  always_comb begin
    enMask = sr_mask_i | NMI_MASK;
    if (state_q == ISR) begin
`ifdef INT_NEST_EN
      enMask = sr_mask_i | NMI_MASK;
`else
      enMask = NMI_MASK;
`endif
    end else if (state_q == JISR) begin
      enMask = '0;
    end
  end

  assign elig = cand & enMask;
  assign take = |elig;

  // Reported bits are exactly the eligible ones on the entry edge.
  cause_latch #(
    .WIDTH (NCAUSE)
  ) u_cause_latch (
    .clk    (clk),
    .rst_n  (rst_n),
    .set_i  (cause_in_i & EXT_BITS),
    .clr_i  (elig),
    .pend_o (pend)
  );

  // Controller FSM with all outputs registered. Entry into JISR captures
  // mca/rpt and starts the one-cycle pulse; an eligible cause in ISR wins
  // over a simultaneous rfe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      jisr_q   <= 1'b0;
      mca_q    <= '0;
      rpt_q    <= 1'b0;
      isr_pc_q <= '0;
      in_isr_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (take) begin
            state_q  <= JISR;
            jisr_q   <= 1'b1;
            isr_pc_q <= SISR;
            mca_q    <= elig;
            rpt_q    <= |(elig & RPT_MASK);
          end
        end
        JISR: begin
          state_q  <= ISR;
          jisr_q   <= 1'b0;
          isr_pc_q <= '0;
          in_isr_q <= 1'b1;
        end
        ISR: begin
          if (take) begin
            state_q  <= JISR;
            jisr_q   <= 1'b1;
            isr_pc_q <= SISR;
            mca_q    <= elig;
            rpt_q    <= |(elig & RPT_MASK);
          end else if (rfe_i) begin
            state_q  <= RUN;
            in_isr_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= RUN;
          jisr_q   <= 1'b0;
          isr_pc_q <= '0;
          in_isr_q <= 1'b0;
        end
      endcase
    end
  end

  assign jisr_o   = jisr_q;
  assign mca_o    = mca_q;
  assign rpt_o    = rpt_q;
  assign isr_pc_o = isr_pc_q;
  assign in_isr_o = in_isr_q;
  assign pend_o   = pend;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Self-checking bench for interrupt_ctrl: directed scenarios followed by
// random traffic, all checked against a cycle-level behavioural model.
module tb_interrupt_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        commit;
   logic [22:0] causeIn;
   logic [22:0] srMask;
   logic        rfe;
   logic        jisr;
   logic [22:0] mca;
   logic        rpt;
   logic [31:0] isrPc;
   logic        inIsr;
   logic [22:0] pend;

   int compared   = 0;
   int mismatched = 0;

   localparam logic [22:0] ALL = 23'h7fffff;
   localparam logic [22:0] EXT = 23'h7ff000;
   localparam logic [22:0] NMI = 23'h000001;
   localparam logic [22:0] RPT = 23'h000060;
   localparam logic [31:0] ENTRY = 32'h0000_0100;
   localparam logic [22:0] B12 = 23'h001000;
   localparam logic [22:0] B13 = 23'h002000;
   localparam logic [22:0] B14 = 23'h004000;
   localparam logic [22:0] B15 = 23'h008000;
`ifdef INT_NEST_EN
   localparam bit NEST = 1'b1;
`else
   localparam bit NEST = 1'b0;
`endif

   // Model of what software sees: whether a handler is running, whether the
   // entry pulse is showing, which external sources are still owed, and the
   // last reported cause vector.
   bit          mInIsr;
   bit          mPulse;
   logic [22:0] mPend;
   logic [22:0] mMca;
   bit          mRpt;

   // 10 ns clock
   always #5 clk = ~clk;

   interrupt_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .commit_i   (commit),
      .cause_in_i (causeIn),
      .sr_mask_i  (srMask),
      .rfe_i      (rfe),
      .jisr_o     (jisr),
      .mca_o      (mca),
      .rpt_o      (rpt),
      .isr_pc_o   (isrPc),
      .in_isr_o   (inIsr),
      .pend_o     (pend)
   );

   // Everything cleared, as after a reset
   task automatic modelReset();
      mInIsr = 0;
      mPulse = 0;
      mPend  = '0;
      mMca   = '0;
      mRpt   = 0;
   endtask

   // Advance the model by one clock edge using the inputs held at that edge
   task automatic modelEdge();
      logic [22:0] cand;
      logic [22:0] allowed;
      logic [22:0] elig;
      logic [22:0] extNow;
      extNow = causeIn & EXT;
      cand   = mPend | extNow | (commit ? (causeIn & ~EXT) : 23'h0);
      if (mPulse) begin
         mPulse = 0;
         mInIsr = 1;
         mPend  = mPend | extNow;
      end else begin
         allowed = (mInIsr && !NEST) ? NMI : (srMask | NMI);
         elig    = cand & allowed;
         if (elig != 0) begin
            mPulse = 1;
            mMca   = elig;
            mRpt   = ((elig & RPT) != 0);
            mPend  = (mPend & ~elig) | extNow;
         end else begin
            if (mInIsr && rfe) mInIsr = 0;
            mPend = mPend | extNow;
         end
      end
   endtask

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkVal({tag, ".jisr"},   {31'h0, jisr},  {31'h0, mPulse});
      checkVal({tag, ".mca"},    {9'h0, mca},    {9'h0, mMca});
      checkVal({tag, ".rpt"},    {31'h0, rpt},   {31'h0, mRpt});
      checkVal({tag, ".isr_pc"}, isrPc,          mPulse ? ENTRY : 32'h0);
      checkVal({tag, ".in_isr"}, {31'h0, inIsr}, {31'h0, mInIsr});
      checkVal({tag, ".pend"},   {9'h0, pend},   {9'h0, mPend});
   endtask

   // Hold inputs across one rising edge, then check 1 ns after it
   task automatic applyStimulus(input string tag, input logic cm, input logic [22:0] cause,
                                input logic [22:0] mask, input logic r);
      commit  = cm;
      causeIn = cause;
      srMask  = mask;
      rfe     = r;
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput(tag);
   endtask

   // Let everything outstanding fire and return to RUN, bounded
   task automatic drainToRun(input string tag);
      for (int i = 0; i < 40; i++) begin
         if (!mInIsr && !mPulse && mPend == 0) break;
         applyStimulus(tag, 1'b0, 23'h0, ALL, 1'b1);
      end
      checkVal({tag, ".idle"}, {31'h0, (mInIsr | mPulse)}, 32'h0);
   endtask

   initial begin
      rst_n   = 1'b0;
      commit  = 1'b0;
      causeIn = '0;
      srMask  = '0;
      rfe     = 1'b0;
      modelReset();
      #12;
      checkOutput("reset");
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus("idle", 1'b0, 23'h0, ALL, 1'b0);

      // Internal repeat-type fault
      applyStimulus("t2.entry", 1'b1, 23'h000020, ALL, 1'b0);
      checkVal("t2.mca_const", {9'h0, mca}, 32'h0000_0020);
      checkVal("t2.rpt_const", {31'h0, rpt}, 32'h1);
      checkVal("t2.pc_const", isrPc, 32'h0000_0100);
      applyStimulus("t2.isr", 1'b0, 23'h0, ALL, 1'b0);
      checkVal("t2.pulse_end", {31'h0, jisr}, 32'h0);
      applyStimulus("t2.rfe", 1'b0, 23'h0, ALL, 1'b1);

      // Internal cause without commit is dropped
      applyStimulus("nocommit", 1'b0, 23'h000040, ALL, 1'b0);
      applyStimulus("nocommit2", 1'b0, 23'h0, ALL, 1'b0);

      // Masked external stays pending until enabled
      applyStimulus("t3.masked", 1'b0, B12, ALL & ~B12, 1'b0);
      checkVal("t3.pend12", {9'h0, pend}, {9'h0, B12});
      applyStimulus("t3.wait", 1'b0, 23'h0, ALL & ~B12, 1'b0);
      applyStimulus("t3.enable", 1'b0, 23'h0, ALL, 1'b0);
      checkVal("t3.mca_const", {9'h0, mca}, {9'h0, B12});
      checkVal("t3.pend_clr", {9'h0, pend}, 32'h0);
      drainToRun("t3.drain");

`ifndef INT_NEST_EN
      // No nesting: maskable external waits for rfe
      applyStimulus("t4.entry", 1'b1, 23'h000020, ALL, 1'b0);
      applyStimulus("t4.isr", 1'b0, 23'h0, ALL, 1'b0);
      applyStimulus("t4.pulse13", 1'b0, B13, ALL, 1'b0);
      checkVal("t4.no_jisr", {31'h0, jisr}, 32'h0);
      applyStimulus("t4.rfe", 1'b0, 23'h0, ALL, 1'b1);
      applyStimulus("t4.fire", 1'b0, 23'h0, ALL, 1'b0);
      checkVal("t4.mca_const", {9'h0, mca}, {9'h0, B13});
      applyStimulus("t4.isr2", 1'b0, 23'h0, ALL, 1'b0);
`else
      // Nesting: enabled external is taken inside the ISR
      applyStimulus("t6.entry", 1'b1, 23'h000020, ALL, 1'b0);
      applyStimulus("t6.isr", 1'b0, 23'h0, ALL, 1'b0);
      applyStimulus("t6.nest", 1'b0, B14, ALL, 1'b0);
      checkVal("t6.mca_const", {9'h0, mca}, {9'h0, B14});
      applyStimulus("t6.isr2", 1'b0, 23'h0, ALL, 1'b0);
`endif

      // NMI fault wins over simultaneous rfe
      applyStimulus("t5.both", 1'b1, NMI, ALL, 1'b1);
      checkVal("t5.mca_const", {9'h0, mca}, 32'h1);
      checkVal("t5.in_isr", {31'h0, inIsr}, 32'h1);
      drainToRun("t5.drain");

      // Asynchronous reset in the middle of the JISR pulse
      applyStimulus("t1.entry", 1'b1, 23'h000020 | B15, ALL & ~B15, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkVal("t1.jisr_async", {31'h0, jisr}, 32'h0);
      checkVal("t1.mca_async", {9'h0, mca}, 32'h0);
      checkVal("t1.in_isr_async", {31'h0, inIsr}, 32'h0);
      checkVal("t1.pend_async", {9'h0, pend}, 32'h0);
      modelReset();
      commit  = 1'b0;
      causeIn = '0;
      @(posedge clk);
      #1;
      checkOutput("t1.held");
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus("t1.run", 1'b0, 23'h0, ALL, 1'b0);
      applyStimulus("t1.refire", 1'b1, 23'h000040, ALL, 1'b0);
      drainToRun("t1.drain");

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [22:0] c;
         logic [22:0] m;
         c = 23'($urandom & $urandom & $urandom);
         m = ($urandom_range(0, 3) == 0) ? 23'($urandom) : ALL;
         applyStimulus("rand", 1'($urandom_range(0, 1)), c, m, ($urandom_range(0, 3) == 0));
      end
      drainToRun("rand.drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
